// File: rtl/irig_bcd_to_epoch_if.sv
// irig_bcd_to_epoch_if: request/result bundle for the IRIG BCD to epoch converter.
// The master drives the BCD time stamp and strobe; the slave returns the result.
interface irig_bcd_to_epoch_if #(
  parameter int OUT_W = 32
);
  logic             In_vld;
  logic             In_rdy;
  logic [6:0]       Bcd_sec;
  logic [6:0]       Bcd_min;
  logic [5:0]       Bcd_hour;
  logic [9:0]       Bcd_day;
  logic [7:0]       Bcd_year;
  logic [OUT_W-1:0] Out_seconds;
  logic             Out_vld;
  logic             Out_err;
  logic             Out_drop;

  modport master (
    output In_vld, Bcd_sec, Bcd_min, Bcd_hour, Bcd_day, Bcd_year,
    input  In_rdy, Out_seconds, Out_vld, Out_err, Out_drop
  );

  modport slave (
    input  In_vld, Bcd_sec, Bcd_min, Bcd_hour, Bcd_day, Bcd_year,
    output In_rdy, Out_seconds, Out_vld, Out_err, Out_drop
  );
endinterface

// File: rtl/irig_bcd_to_epoch.sv
// irig_bcd_to_epoch: converts a captured IRIG BCD time stamp into a binary
// seconds count. The day and year contributions are accumulated one day/year
// per cycle so the datapath needs adders only (no multipliers).
module irig_bcd_to_epoch #(
  parameter int OUT_W   = 32,
  parameter int MODE    = 0,
  parameter int LEAP_EN = 1
) (
  input  logic               Clk,
  input  logic               Rst,
  irig_bcd_to_epoch_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_DAY   = 3'd2,
    S_YEAR  = 3'd3,
    S_SUM   = 3'd4
  } state_t;

  localparam logic             LEAP_ON   = (LEAP_EN != 32'sd0);
  localparam logic             YEAR_ON   = (MODE == 32'sd0);
  localparam logic [OUT_W-1:0] DAY_SECS  = OUT_W'(32'd86400);
  localparam logic [OUT_W-1:0] YEAR_SECS = OUT_W'(32'd31536000);
  localparam logic [OUT_W-1:0] ZERO_W    = {OUT_W{1'b0}};

  // Two BCD digits to binary; tens*10 is formed as (t<<3)+(t<<1).
  function automatic logic [7:0] bcd2_bin(input logic [3:0] tens, input logic [3:0] units);
    logic [7:0] t;
    t = {4'd0, tens};
    return (t << 3) + (t << 1) + {4'd0, units};
  endfunction

  // A BCD digit is malformed when it encodes a value above nine.
  function automatic logic nib_bad(input logic [3:0] n);
    return (n > 4'd9);
  endfunction

  state_t           state_q, state_d;
  logic             rdy_q, rdy_d;
  logic [6:0]       sec_bcd_q, sec_bcd_d;
  logic [6:0]       min_bcd_q, min_bcd_d;
  logic [5:0]       hour_bcd_q, hour_bcd_d;
  logic [9:0]       day_bcd_q, day_bcd_d;
  logic [7:0]       year_bcd_q, year_bcd_d;
  logic [OUT_W-1:0] sec_q, sec_d;
  logic [OUT_W-1:0] day_acc_q, day_acc_d;
  logic [OUT_W-1:0] year_acc_q, year_acc_d;
  logic [9:0]       day_cnt_q, day_cnt_d;
  logic [7:0]       year_cnt_q, year_cnt_d;
  logic [1:0]       leap_ph_q, leap_ph_d;
  logic             err_q, err_d;
  logic             hold_q, hold_d;
  logic [OUT_W-1:0] out_seconds_q, out_seconds_d;
  logic             out_vld_q, out_vld_d;
  logic             out_err_q, out_err_d;
  logic             out_drop_q, out_drop_d;

  logic [7:0]  s_bin_s, m_bin_s, h_bin_s, y_bin_s;
  logic [9:0]  d_bin_s, d_hund_s, day_max_s;
  logic [31:0] s32_s, m32_s, h32_s, sec_calc_s;
  logic        nib_err_s, leap_year_s, err_s;

  // Decode the captured BCD fields to binary and validate them.
  always_comb begin
    s_bin_s    = bcd2_bin({1'b0, sec_bcd_q[6:4]}, sec_bcd_q[3:0]);
    m_bin_s    = bcd2_bin({1'b0, min_bcd_q[6:4]}, min_bcd_q[3:0]);
    h_bin_s    = bcd2_bin({2'b00, hour_bcd_q[5:4]}, hour_bcd_q[3:0]);
    y_bin_s    = bcd2_bin(year_bcd_q[7:4], year_bcd_q[3:0]);
    d_hund_s   = {8'd0, day_bcd_q[9:8]};
    d_bin_s    = {2'b00, bcd2_bin(day_bcd_q[7:4], day_bcd_q[3:0])}
               + (d_hund_s << 6) + (d_hund_s << 5) + (d_hund_s << 2);
    s32_s      = {24'd0, s_bin_s};
    m32_s      = {24'd0, m_bin_s};
    h32_s      = {24'd0, h_bin_s};
    // 60 = 32+16+8+4 and 3600 = 2048+1024+512+16
    sec_calc_s = s32_s
               + (m32_s << 5) + (m32_s << 4) + (m32_s << 3) + (m32_s << 2)
               + (h32_s << 11) + (h32_s << 10) + (h32_s << 9) + (h32_s << 4);
    nib_err_s  = nib_bad(sec_bcd_q[3:0]) | nib_bad(min_bcd_q[3:0]) | nib_bad(hour_bcd_q[3:0])
               | nib_bad(day_bcd_q[3:0]) | nib_bad(day_bcd_q[7:4])
               | nib_bad(year_bcd_q[3:0]) | nib_bad(year_bcd_q[7:4]);
    leap_year_s = LEAP_ON & (y_bin_s[1:0] == 2'd0);
    day_max_s   = leap_year_s ? 10'd366 : 10'd365;
    err_s       = nib_err_s | (s_bin_s > 8'd60) | (m_bin_s > 8'd59) | (h_bin_s > 8'd23)
                | (d_bin_s == 10'd0) | (d_bin_s > day_max_s);
  end

  // Next-state and datapath updates for the conversion sequencer.
  always_comb begin
    state_d       = state_q;
    sec_bcd_d     = sec_bcd_q;
    min_bcd_d     = min_bcd_q;
    hour_bcd_d    = hour_bcd_q;
    day_bcd_d     = day_bcd_q;
    year_bcd_d    = year_bcd_q;
    sec_d         = sec_q;
    day_acc_d     = day_acc_q;
    year_acc_d    = year_acc_q;
    day_cnt_d     = day_cnt_q;
    year_cnt_d    = year_cnt_q;
    leap_ph_d     = leap_ph_q;
    err_d         = err_q;
    hold_d        = hold_q;
    out_seconds_d = out_seconds_q;
    out_vld_d     = 1'b0;
    out_err_d     = 1'b0;
    out_drop_d    = bus.In_vld & ~rdy_q;

    case (state_q)
      S_IDLE: begin
        if (bus.In_vld) begin
          sec_bcd_d  = bus.Bcd_sec;
          min_bcd_d  = bus.Bcd_min;
          hour_bcd_d = bus.Bcd_hour;
          day_bcd_d  = bus.Bcd_day;
          year_bcd_d = bus.Bcd_year;
          state_d    = S_CHECK;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_CHECK: begin
        sec_d      = OUT_W'(sec_calc_s);
        err_d      = err_s;
        hold_d     = 1'b0;
        day_acc_d  = ZERO_W;
        year_acc_d = ZERO_W;
        day_cnt_d  = d_bin_s - 10'd1;
        year_cnt_d = y_bin_s;
        leap_ph_d  = 2'd0;
        state_d    = err_s ? S_SUM : S_DAY;
      end
      S_DAY: begin
        if (day_cnt_q != 10'd0) begin
          day_acc_d = day_acc_q + DAY_SECS;
          day_cnt_d = day_cnt_q - 10'd1;
        end else begin
          state_d   = YEAR_ON ? S_YEAR : S_SUM;
        end
      end
      S_YEAR: begin
        if (year_cnt_q != 8'd0) begin
          // Year k of the century carries a leap day when k mod 4 = 0.
          year_acc_d = year_acc_q + YEAR_SECS
                     + ((LEAP_ON && (leap_ph_q == 2'd0)) ? DAY_SECS : ZERO_W);
          leap_ph_d  = leap_ph_q + 2'd1;
          year_cnt_d = year_cnt_q - 8'd1;
        end else begin
          state_d    = S_SUM;
        end
      end
      S_SUM: begin
        // A rejected request waits one extra cycle so its result lands at a fixed latency.
        if (err_q && !hold_q) begin
          hold_d = 1'b1;
        end else begin
          state_d   = S_IDLE;
          out_vld_d = 1'b1;
          out_err_d = err_q;
          if (!err_q) begin
            out_seconds_d = sec_q + day_acc_q + year_acc_q;
          end else begin
            out_seconds_d = out_seconds_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rdy_d = (state_d == S_IDLE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= S_IDLE;
      rdy_q         <= 1'b1;
      sec_bcd_q     <= 7'd0;
      min_bcd_q     <= 7'd0;
      hour_bcd_q    <= 6'd0;
      day_bcd_q     <= 10'd0;
      year_bcd_q    <= 8'd0;
      sec_q         <= ZERO_W;
      day_acc_q     <= ZERO_W;
      year_acc_q    <= ZERO_W;
      day_cnt_q     <= 10'd0;
      year_cnt_q    <= 8'd0;
      leap_ph_q     <= 2'd0;
      err_q         <= 1'b0;
      hold_q        <= 1'b0;
      out_seconds_q <= ZERO_W;
      out_vld_q     <= 1'b0;
      out_err_q     <= 1'b0;
      out_drop_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rdy_q         <= rdy_d;
      sec_bcd_q     <= sec_bcd_d;
      min_bcd_q     <= min_bcd_d;
      hour_bcd_q    <= hour_bcd_d;
      day_bcd_q     <= day_bcd_d;
      year_bcd_q    <= year_bcd_d;
      sec_q         <= sec_d;
      day_acc_q     <= day_acc_d;
      year_acc_q    <= year_acc_d;
      day_cnt_q     <= day_cnt_d;
      year_cnt_q    <= year_cnt_d;
      leap_ph_q     <= leap_ph_d;
      err_q         <= err_d;
      hold_q        <= hold_d;
      out_seconds_q <= out_seconds_d;
      out_vld_q     <= out_vld_d;
      out_err_q     <= out_err_d;
      out_drop_q    <= out_drop_d;
    end
  end

  assign bus.In_rdy      = rdy_q;
  assign bus.Out_seconds = out_seconds_q;
  assign bus.Out_vld     = out_vld_q;
  assign bus.Out_err     = out_err_q;
  assign bus.Out_drop    = out_drop_q;

endmodule
